// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, MA and memory handshake signals; slave = arbiter view, master = pipeline/memory view
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        ma_req;
  logic        ma_we;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic [31:0] ma_rdata;
  logic        ma_ready;
  logic        ma_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport slave (
    input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, if_stall, ma_rdata, ma_ready, ma_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, if_stall, ma_rdata, ma_ready, ma_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and MA ports (clk, reset, bus = fetch/MA/memory handshakes)
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DATA_RUN);
  typedef enum logic [1:0] {IDLE, IF_BUSY, MA_BUSY} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] run_cnt;
  logic if_v, ma_v;
  // a port whose ready pulse is high this cycle has just been served, so its held request is stale
  assign if_v = bus.if_req & ~bus.if_ready;
  assign ma_v = bus.ma_req & ~bus.ma_ready;
  assign bus.if_stall = bus.if_req & ~bus.if_ready;
  assign bus.ma_stall = bus.ma_req & ~bus.ma_ready;
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (ma_v && (!if_v || run_cnt < RUN_MAX)) ? MA_BUSY : if_v ? IF_BUSY : IDLE;
    else if (bus.mem_ack)
      state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ready  <= 1'b0;
      bus.ma_ready  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.ma_rdata  <= '0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.ma_ready <= 1'b0;
      if (state == IDLE && state_nxt == MA_BUSY) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.ma_we;
        bus.mem_addr  <= bus.ma_addr;
        bus.mem_wdata <= bus.ma_wdata;
        run_cnt       <= !bus.if_req ? '0 : run_cnt == RUN_MAX ? run_cnt : run_cnt + 1'b1;
      end else if (state == IDLE && state_nxt == IF_BUSY) begin
        bus.mem_req  <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= bus.if_addr;
        run_cnt      <= '0;
      end else if (state != IDLE && bus.mem_ack) begin
        bus.mem_req <= 1'b0;
        if (state == IF_BUSY) begin
          bus.if_ready <= 1'b1;
          bus.if_rdata <= bus.mem_rdata;
        end else begin
          bus.ma_ready <= 1'b1;
          bus.ma_rdata <= bus.mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a small memory model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int lat;
  logic spur;
  int wcnt = 0;
  int ma_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [0:255];
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.MAX_DATA_RUN(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // memory acks once mem_req has been high for lat+1 cycles; spur forces an ack at any time
  always @(posedge clk) wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
  assign bus.mem_ack = (bus.mem_req && wcnt == lat) || spur;
  assign bus.mem_rdata = (bus.mem_addr == 32'h40) ? 32'h8C080004 : mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  always @(posedge clk) if (bus.ma_ready) ma_cnt <= ma_cnt + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string p);
    chk({p, "_mem_req"}, 32'(bus.mem_req), 0);
    chk({p, "_mem_we"}, 32'(bus.mem_we), 0);
    chk({p, "_mem_addr"}, bus.mem_addr, 0);
    chk({p, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({p, "_if_ready"}, 32'(bus.if_ready), 0);
    chk({p, "_ma_ready"}, 32'(bus.ma_ready), 0);
    chk({p, "_if_rdata"}, bus.if_rdata, 0);
    chk({p, "_ma_rdata"}, bus.ma_rdata, 0);
  endtask
  initial begin
    int base;
    int ng;
    logic prev;
    logic [31:0] g [6];
    logic [31:0] gexp [6];
    gexp = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h40, 32'h100};
    reset = 1'b1;
    lat = 0;
    spur = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.ma_req = 1'b0;
    bus.ma_we = 1'b0;
    bus.ma_addr = '0;
    bus.ma_wdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    // fetch alone, 1-cycle ack
    reset = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    chk("if_stall_c0", 32'(bus.if_stall), 1);
    chk("mem_req_c0", 32'(bus.mem_req), 0);
    @(negedge clk);
    chk("if_mem_req_c1", 32'(bus.mem_req), 1);
    chk("if_mem_we_c1", 32'(bus.mem_we), 0);
    chk("if_mem_addr_c1", bus.mem_addr, 32'h40);
    chk("if_stall_c1", 32'(bus.if_stall), 1);
    chk("if_ready_c1", 32'(bus.if_ready), 0);
    @(negedge clk);
    chk("if_ready_c2", 32'(bus.if_ready), 1);
    chk("if_rdata_c2", bus.if_rdata, 32'h8C080004);
    chk("if_stall_c2", 32'(bus.if_stall), 0);
    chk("if_mem_req_c2", 32'(bus.mem_req), 0);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("if_ready_c3", 32'(bus.if_ready), 0);
    chk("if_rdata_held", bus.if_rdata, 32'h8C080004);
    // store then load to the same address
    base = ma_cnt;
    bus.ma_req = 1'b1;
    bus.ma_we = 1'b1;
    bus.ma_addr = 32'h100;
    bus.ma_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("st_mem_req", 32'(bus.mem_req), 1);
    chk("st_mem_we", 32'(bus.mem_we), 1);
    chk("st_mem_addr", bus.mem_addr, 32'h100);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_ma_ready", 32'(bus.ma_ready), 1);
    bus.ma_we = 1'b0;
    @(negedge clk);
    chk("ld_gap_ready", 32'(bus.ma_ready), 0);
    chk("ld_gap_mem_req", 32'(bus.mem_req), 0);
    @(negedge clk);
    chk("ld_mem_req", 32'(bus.mem_req), 1);
    chk("ld_mem_we", 32'(bus.mem_we), 0);
    @(negedge clk);
    chk("ld_ma_ready", 32'(bus.ma_ready), 1);
    chk("ld_ma_rdata", bus.ma_rdata, 32'hDEADBEEF);
    bus.ma_req = 1'b0;
    @(negedge clk);
    chk("st_ld_pulses", 32'(ma_cnt - base), 2);
    // variable latency load: ack in the sixth cycle of mem_req
    lat = 5;
    base = ma_cnt;
    bus.ma_req = 1'b1;
    bus.ma_we = 1'b0;
    bus.ma_addr = 32'h100;
    bus.ma_wdata = 32'h12345678;
    #1;
    chk("vl_stall_c0", 32'(bus.ma_stall), 1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("vl_addr_c%0d", i), bus.mem_addr, 32'h100);
      chk($sformatf("vl_wdata_c%0d", i), bus.mem_wdata, 32'h12345678);
      chk($sformatf("vl_stall_c%0d", i), 32'(bus.ma_stall), 1);
      chk($sformatf("vl_ready_c%0d", i), 32'(bus.ma_ready), 0);
    end
    @(negedge clk);
    chk("vl_ready", 32'(bus.ma_ready), 1);
    chk("vl_stall_end", 32'(bus.ma_stall), 0);
    chk("vl_rdata", bus.ma_rdata, 32'hDEADBEEF);
    bus.ma_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("vl_pulses", 32'(ma_cnt - base), 1);
    // spurious ack while idle
    lat = 0;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("sp_mem_req", 32'(bus.mem_req), 0);
    chk("sp_if_ready", 32'(bus.if_ready), 0);
    chk("sp_ma_ready", 32'(bus.ma_ready), 0);
    @(negedge clk);
    chk("sp_mem_req2", 32'(bus.mem_req), 0);
    chk("sp_ma_ready2", 32'(bus.ma_ready), 0);
    chk("sp_if_rdata", bus.if_rdata, 32'h8C080004);
    chk("sp_ma_rdata", bus.ma_rdata, 32'hDEADBEEF);
    // reset while MA_BUSY, then a late ack
    lat = 20;
    base = ma_cnt;
    bus.ma_req = 1'b1;
    bus.ma_addr = 32'h100;
    @(negedge clk);
    chk("rm_mem_req", 32'(bus.mem_req), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.ma_req = 1'b0;
    spur = 1'b1;
    chk_reset_vals("rm");
    @(negedge clk);
    spur = 1'b0;
    chk("rm_ma_ready1", 32'(bus.ma_ready), 0);
    chk("rm_mem_req1", 32'(bus.mem_req), 0);
    @(negedge clk);
    chk("rm_ma_ready2", 32'(bus.ma_ready), 0);
    chk("rm_mem_req2", 32'(bus.mem_req), 0);
    chk("rm_ma_rdata", bus.ma_rdata, 0);
    chk("rm_pulses", 32'(ma_cnt - base), 0);
    // fairness: MA held, fetch waiting in every cycle except MA ready cycles
    lat = 0;
    ng = 0;
    prev = 1'b0;
    bus.ma_req = 1'b1;
    bus.ma_we = 1'b0;
    bus.ma_addr = 32'h100;
    bus.if_addr = 32'h40;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      bus.if_req = !bus.ma_ready;
      #1;
      if (bus.mem_req && !prev) begin
        g[ng] = bus.mem_addr;
        ng++;
      end
      prev = bus.mem_req;
      @(negedge clk);
    end
    bus.ma_req = 1'b0;
    bus.if_req = 1'b0;
    chk("fair_grants", 32'(ng), 6);
    for (int k = 0; k < ng; k++) chk($sformatf("fair_grant%0d", k), g[k], gexp[k]);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
